// File: rtl/mandel_iterator.sv
// mandel_iterator: escape-time engine, one z^2+c step per clock.
// Q10.21 fixed point; optional overflow escape via MANDEL_OVF_ESC_EN.
//
// Ports:
//   clock, rst         clock, async active-low reset
//   in_valid/in_ready  point handshake (c_re, c_im, px_x, px_y)
//   out_valid/out_ready result handshake
//   iter_count         escape index, or MAX_ITER if bounded
//   escaped            1 = |z|^2 > 4.0 (or product overflow)
//   out_x, out_y       pixel coordinates of the result
module mandel_iterator #(
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8,
  parameter int FRAC     = 21
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       c_re,
  input  logic [31:0]       c_im,
  input  logic [9:0]        px_x,
  input  logic [9:0]        px_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y
);

  localparam int HI = FRAC + 31;
  localparam logic signed [32:0] FOUR =
    33'(4 * (2 ** FRAC));

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t state;

  logic signed [31:0] cr;
  logic signed [31:0] ci;
  logic signed [31:0] zr;
  logic signed [31:0] zi;
  logic [ITER_W-1:0]  n;

  logic signed [63:0] p_rr;
  logic signed [63:0] p_ii;
  logic signed [63:0] p_ri;
  logic signed [31:0] zr2;
  logic signed [31:0] zi2;
  logic signed [31:0] zri;
  logic signed [31:0] zr_nx;
  logic signed [31:0] zi_nx;
  logic signed [32:0] mag;
  logic               esc;
  logic               ovf;
  logic               lim;
  logic               unused_bits;

  always_comb begin
    p_rr  = 64'(zr) * 64'(zr);
    p_ii  = 64'(zi) * 64'(zi);
    p_ri  = 64'(zr) * 64'(zi);
    zr2   = p_rr[HI:FRAC];
    zi2   = p_ii[HI:FRAC];
    zri   = p_ri[HI:FRAC];
    // 33-bit sum so two large squares cannot wrap
    mag   = 33'(zr2) + 33'(zi2);
    esc   = mag > FOUR;
    zr_nx = zr2 - zi2 + cr;
    zi_nx = (zri <<< 1) + ci;
    lim   = (n == ITER_W'(MAX_ITER));
`ifdef MANDEL_OVF_ESC_EN
    // integer part must be a pure sign extension
    ovf = !((&p_rr[63:HI]) || !(|p_rr[63:HI]))
       || !((&p_ii[63:HI]) || !(|p_ii[63:HI]))
       || !((&p_ri[63:HI]) || !(|p_ri[63:HI]));
`else
    ovf = 1'b0;
`endif
  end

  assign unused_bits = ^{p_rr[63:HI+1],
                         p_ii[63:HI+1],
                         p_ri[63:HI+1],
                         p_rr[FRAC-1:0],
                         p_ii[FRAC-1:0],
                         p_ri[FRAC-1:0]};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      iter_count <= '0;
      escaped    <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      cr         <= '0;
      ci         <= '0;
      zr         <= '0;
      zi         <= '0;
      n          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cr       <= c_re;
            ci       <= c_im;
            out_x    <= px_x;
            out_y    <= px_y;
            zr       <= '0;
            zi       <= '0;
            n        <= '0;
            in_ready <= 1'b0;
            state    <= ITER;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ITER: begin
          if (esc || ovf) begin
            escaped    <= 1'b1;
            iter_count <= n;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (lim) begin
            escaped    <= 1'b0;
            iter_count <= ITER_W'(MAX_ITER);
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            zr <= zr_nx;
            zi <= zi_nx;
            n  <= n + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // ready in the first IDLE cycle
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iterator.sv
// tb_mandel_iterator: scoreboard bench for mandel_iterator.
// Directed points with hand-computed counts and latencies.
module tb_mandel_iterator;

  logic        clock;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] c_re;
  logic [31:0] c_im;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  iter_count;
  logic        escaped;
  logic [9:0]  out_x;
  logic [9:0]  out_y;

  mandel_iterator dut (
    .clock      (clock),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .c_re       (c_re),
    .c_im       (c_im),
    .px_x       (px_x),
    .px_y       (px_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .iter_count (iter_count),
    .escaped    (escaped),
    .out_x      (out_x),
    .out_y      (out_y)
  );

  typedef struct {
    int cnt;
    bit esc;
    int x;
    int y;
    int acc;
    int lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   seen = 0;
  int   lat_seen = -1;

  localparam logic [31:0] ZERO = 32'h0000_0000;
  localparam logic [31:0] ONE  = 32'h0020_0000;
  localparam logic [31:0] MONE = 32'hFFE0_0000;
  localparam logic [31:0] TWO  = 32'h0040_0000;
  localparam logic [31:0] MTWO = 32'hFFC0_0000;
  localparam logic [31:0] BIG  = 32'h3FE0_0000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm,
                     input longint act,
                     input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  // monitor: samples just after the falling edge
  always @(negedge clock) begin
    exp_t e;
    #1;
    if (!rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        lat_seen = (q.size() > 0) ? cyc - q[0].acc : -1;
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("iter_count", iter_count, e.cnt);
          chk("escaped", escaped, e.esc);
          chk("out_x", out_x, e.x);
          chk("out_y", out_y, e.y);
          chk("latency", lat_seen, e.lat);
        end
        seen = 0;
      end
    end
  end

  task automatic send(input logic [31:0] r,
                      input logic [31:0] i,
                      input int x, input int y,
                      input int cnt, input bit e,
                      input bit push);
    exp_t t;
    int w;
    @(negedge clock);
    c_re = r;
    c_im = i;
    px_x = 10'(x);
    px_y = 10'(y);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    t.cnt = cnt;
    t.esc = e;
    t.x = x;
    t.y = y;
    t.acc = cyc + 1;
    t.lat = cnt + 1;
    if (push) q.push_back(t);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() > 0 && w < 2000) begin
      @(negedge clock);
      w++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int w;
    bit ok;
    exp_t t;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    c_re = '0;
    c_im = '0;
    px_x = '0;
    px_y = '0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_escaped", escaped, 0);
    chk("rst_out_xy", {out_x, out_y}, 0);
    #20;
    @(negedge clock);
    rst = 1'b1;

    send(ZERO, ZERO, 5, 7, 255, 0, 1);
    drain();
    send(TWO, ZERO, 10, 20, 2, 1, 1);
    drain();
    send(MTWO, ZERO, 1023, 1023, 255, 0, 1);
    drain();
`ifdef MANDEL_OVF_ESC_EN
    send(BIG, ZERO, 3, 4, 1, 1, 1);
`else
    send(BIG, ZERO, 3, 4, 255, 0, 1);
`endif
    drain();
    send(ONE, ZERO, 100, 200, 3, 1, 1);
    drain();
    send(ZERO, TWO, 640, 480, 2, 1, 1);
    drain();
    send(MONE, ONE, 0, 1, 3, 1, 1);
    drain();

    // backpressure with a new point waiting
    out_ready = 1'b0;
    send(TWO, ZERO, 1, 2, 2, 1, 1);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("bp_valid_seen", out_valid, 1);
    c_re = ONE;
    c_im = ONE;
    px_x = 10'd3;
    px_y = 10'd4;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      ok = out_valid && iter_count == 8'd2
        && escaped && out_x == 10'd1
        && out_y == 10'd2 && !in_ready;
      chk("bp_hold", ok, 1);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp_ready_after", in_ready, 1);
    t.cnt = 2;
    t.esc = 1;
    t.x = 3;
    t.y = 4;
    t.acc = cyc + 1;
    t.lat = 3;
    q.push_back(t);
    @(negedge clock);
    chk("bp_accepted", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset in the middle of an iteration
    send(ZERO, ZERO, 11, 12, 255, 0, 0);
    repeat (49) @(negedge clock);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_iter_count", iter_count, 0);
    chk("mid_rst_out_x", out_x, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", in_ready, 1);
    send(TWO, ZERO, 9, 9, 2, 1, 1);
    drain();
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
